// File: rtl/ysyx_24120013_exu_pkg.sv
// ==== ysyx_24120013_exu_pkg : command/state encodings for the multi-cycle EXU | rev 1.0 ====
`default_nettype none

package ysyx_24120013_exu_pkg;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_ADDI  = 4'd1,
    CMD_ADD   = 4'd2,
    CMD_SUB   = 4'd3,
    CMD_AND   = 4'd4,
    CMD_OR    = 4'd5,
    CMD_XOR   = 4'd6,
    CMD_SLTU  = 4'd7,
    CMD_SLT   = 4'd8,
    CMD_MUL   = 4'd9,
    CMD_RSV10 = 4'd10,
    CMD_RSV11 = 4'd11,
    CMD_RSV12 = 4'd12,
    CMD_RSV13 = 4'd13,
    CMD_RSV14 = 4'd14,
    CMD_RSV15 = 4'd15
  } exu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exu_state_e;

  localparam logic [3:0] ILLEGAL_CMD_MIN = 4'd10;
  localparam logic [3:0] ILLEGAL_CMD_MAX = 4'd15;

endpackage

`default_nettype wire

// File: rtl/ysyx_24120013_mul_iter.sv
// ==== ysyx_24120013_mul_iter : iterative shift-add multiplier, one step per cycle | rev 1.0 ====
`default_nettype none

module ysyx_24120013_mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;

  // The first step is folded into the start edge so the last step lands on
  // the DATA_WIDTH-th edge; product is the value after the current step.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = (cnt == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      acc    <= operand_b[0] ? operand_a : '0;
      mcand  <= operand_a << 1;
      mplier <= operand_b >> 1;
      cnt    <= CNT_W'(1);
    end else if (cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_24120013_exu_mc.sv
// ==== ysyx_24120013_exu_mc : multi-cycle execute unit with valid/ready handshakes | rev 1.0 ====
`default_nettype none

module ysyx_24120013_exu_mc
  import ysyx_24120013_exu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [ADDR_WIDTH-1:0] des_addr,
  input  logic [3:0]            command,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  EXU_wen,
  output logic [ADDR_WIDTH-1:0] EXU_waddr,
  output logic [DATA_WIDTH-1:0] EXU_wdata,
  output logic                  illegal
);

  exu_state_e            state, state_next;
  exu_cmd_e              cmd;
  logic                  accept;
  logic                  is_mul;
  logic                  is_illegal;
  logic                  writes_rd;
  logic                  slt_res;
  logic                  sltu_res;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [ADDR_WIDTH-1:0] mul_addr;

  assign cmd        = exu_cmd_e'(command);
  assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid  = (state == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign is_mul     = (cmd == CMD_MUL);
  assign is_illegal = (command >= ILLEGAL_CMD_MIN);
  assign writes_rd  = !is_illegal && (cmd != CMD_NOP);
  assign slt_res    = $signed(src1) < $signed(src2);
  assign sltu_res   = src1 < src2;

  always_comb begin
    alu_res = '0;
    case (cmd)
      CMD_ADDI: alu_res = src1 + imm;
      CMD_ADD:  alu_res = src1 + src2;
      CMD_SUB:  alu_res = src1 - src2;
      CMD_AND:  alu_res = src1 & src2;
      CMD_OR:   alu_res = src1 | src2;
      CMD_XOR:  alu_res = src1 ^ src2;
      CMD_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, sltu_res};
      CMD_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_res};
      default:  alu_res = '0;
    endcase
  end

  ysyx_24120013_mul_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_mul),
    .operand_a (src1),
    .operand_b (src2),
    .done      (mul_done),
    .product   (mul_product)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = accept ? (is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // wen is dropped whenever no result is presented so the register file
  // never sees a stale write outside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      EXU_wen   <= 1'b0;
      EXU_waddr <= '0;
      EXU_wdata <= '0;
      illegal   <= 1'b0;
      mul_addr  <= '0;
    end else if (accept && !is_mul) begin
      EXU_wen   <= writes_rd && (des_addr != '0);
      EXU_waddr <= des_addr;
      EXU_wdata <= alu_res;
      illegal   <= is_illegal;
    end else if (accept) begin
      EXU_wen   <= 1'b0;
      illegal   <= 1'b0;
      mul_addr  <= des_addr;
    end else if ((state == ST_MUL) && mul_done) begin
      EXU_wen   <= (mul_addr != '0);
      EXU_waddr <= mul_addr;
      EXU_wdata <= mul_product;
    end else if ((state == ST_DONE) && out_ready) begin
      EXU_wen   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/ysyx_24120013_exu_mc.md
# ysyx_24120013_exu_mc

Multi-cycle, parametrised execute unit for the single-issue NPC core. It sits between the IDU and the register-file write port. Compared with the single-cycle add-only EXU, it adds a full integer ALU command set, an iterative shift-add multiplier, valid/ready handshakes on both sides, and registered write-back outputs with backpressure hold.

## Interface
Parameters:
- ADDR_WIDTH, 5, register-file address width
- DATA_WIDTH, 32, datapath width (≥ 2)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IDU presents an operation
- in_ready  out  1  EXU accepts an operation this cycle
- imm  in  DATA_WIDTH  immediate operand
- src1  in  DATA_WIDTH  rs1 value
- src2  in  DATA_WIDTH  rs2 value
- des_addr  in  ADDR_WIDTH  rd address
- command  in  4  operation code
- out_valid  out  1  write-back result valid
- out_ready  in  1  write-back stage consumes result
- EXU_wen  out  1  register write enable
- EXU_waddr  out  ADDR_WIDTH  register write address
- EXU_wdata  out  DATA_WIDTH  register write data
- illegal  out  1  the result held on the outputs came from an undefined command

## Operation
- Commands: 0 NOP, 1 ADDI (src1+imm), 2 ADD (src1+src2), 3 SUB (src1−src2), 4 AND, 5 OR, 6 XOR, 7 SLTU, 8 SLT (signed), 9 MUL (low DATA_WIDTH bits of src1×src2). 10–15 are illegal.
- All arithmetic is modulo 2^DATA_WIDTH. Overflow wraps silently. SLT and SLTU write 1 or 0, zero-extended.
- NOP and illegal commands: wdata = 0, wen = 0. Illegal commands also set illegal = 1.
- des_addr == 0: wen = 0, waddr = 0, wdata still computed. Otherwise wen = 1 and waddr = des_addr.
- FSM states:
  - IDLE → DONE when an ALU, NOP, or illegal command is accepted.
  - IDLE → MUL when MUL is accepted.
  - MUL → DONE after the last iteration.
  - DONE → IDLE when out_ready is high and no new operation is accepted in the same cycle.
  - DONE → DONE or MUL when out_ready is high and a new operation is accepted in the same cycle (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is a combinational path from out_ready, and it is allowed.
- out_valid = (state == DONE).
- MUL: operands are latched on acceptance. Each cycle does one step: conditional add of the multiplicand, multiplicand << 1, multiplier >> 1. There is no early termination.

## Timing
- Reset values: state IDLE, out_valid 0, EXU_wen 0, EXU_waddr 0, EXU_wdata 0, illegal 0, MUL counter 0. in_ready = 1 one cycle after reset.
- Acceptance happens at the rising edge where in_valid && in_ready.
- ALU, NOP, illegal: out_valid is high immediately after the acceptance edge (latency 1).
- MUL: in_ready = 0 and out_valid = 0 for DATA_WIDTH−1 cycles. out_valid rises after the DATA_WIDTH-th edge counted from acceptance (32 cycles at default width).
- Backpressure: while out_valid && !out_ready, all outputs hold stable and inputs are ignored.
- Throughput: one ALU op per cycle when out_ready stays high.
- rst during MUL or DONE aborts the operation. No result is emitted, and outputs return to reset values on that edge.
- in_valid while in_ready = 0 is ignored. The IDU must hold its operation until it is accepted.

## Structure
- Package `ysyx_24120013_exu_pkg` holds:
  - the command enum, with names and codes 0–15;
  - the FSM state enum (IDLE, MUL, DONE);
  - the localparam for the illegal-code range.
- Sub-module `ysyx_24120013_mul_iter`, with ports start, operand_a, operand_b, done, product. It contains the iterative multiplier and its log2(DATA_WIDTH)+1-bit counter. All other ALU logic is inline in the top.

## Test plan
- Reset, then ADDI with src1 = 0x10, imm = 0xFFFFFFF0, des_addr = 3, out_ready = 1 → next cycle: out_valid = 1, wen = 1, waddr = 3, wdata = 0x0.
- SLT with src1 = 0x80000000, src2 = 1 → wdata = 1. SLTU with the same operands → wdata = 0. ADD with des_addr = 0 → wen = 0, waddr = 0.
- MUL with src1 = src2 = 0xFFFFFFFF → in_ready low for 31 cycles, out_valid after the 32nd edge, wdata = 0x00000001. MUL with 7 × 6 → 0x2A.
- ADD result with out_ready = 0 for 5 cycles and in_valid held high → outputs stable, nothing accepted. When out_ready rises, the next operation is accepted in that same cycle.
- command = 12 → illegal = 1, wen = 0, wdata = 0. Next legal op → illegal = 0.
- rst asserted 10 cycles into a MUL → out_valid is never asserted for that MUL. in_ready = 1 the cycle after rst deasserts.
